param_update_scheduler: RTL and testbench

Shares the single port of the DSP parameter memory between the DSP core's read path and a host-side parameter writer. Host writes are queued in a FIFO and committed in batches. A committed batch is applied only after the next frame boundary, and only in cycles where the core is not reading, so coefficient updates never land in the middle of a sample frame's processing except when a tear is flagged. The block sits between `dsp_core`'s parameter bus, the host control path and the parameter RAM port, all in the `dsp_clk` domain.

---
 rtl/param_update_scheduler_if.sv | 37 +++
 rtl/param_update_scheduler.sv | 120 ++++++++++++
 tb/tb_param_update_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_update_scheduler_if.sv
// Bundles the DSP read bus, host write/commit path and parameter RAM port
// of the parameter update scheduler.
interface param_update_scheduler_if #(
    parameter int PARAM_WIDTH      = 36,
    parameter int PARAM_ADDR_WIDTH = 10
);
    logic                        frame_start;
    logic                        dsp_rd_en;
    logic [PARAM_ADDR_WIDTH-1:0] dsp_rd_addr;
    logic                        host_wr_valid;
    logic                        host_wr_ready;
    logic [PARAM_ADDR_WIDTH-1:0] host_wr_addr;
    logic [PARAM_WIDTH-1:0]      host_wr_data;
    logic                        host_commit;
    logic                        busy;
    logic                        batch_done;
    logic                        tear_err;
    logic                        clear_err;
    logic [PARAM_ADDR_WIDTH-1:0] mem_addr;
    logic                        mem_rden;
    logic                        mem_wren;
    logic [PARAM_WIDTH-1:0]      mem_data;

    modport master (
        output frame_start, dsp_rd_en, dsp_rd_addr, host_wr_valid, host_wr_addr,
               host_wr_data, host_commit, clear_err,
        input  host_wr_ready, busy, batch_done, tear_err, mem_addr, mem_rden,
               mem_wren, mem_data
    );

    modport slave (
        input  frame_start, dsp_rd_en, dsp_rd_addr, host_wr_valid, host_wr_addr,
               host_wr_data, host_commit, clear_err,
        output host_wr_ready, busy, batch_done, tear_err, mem_addr, mem_rden,
               mem_wren, mem_data
    );
endinterface

// File: rtl/param_update_scheduler.sv
// Shares the parameter RAM port between DSP core reads and batched host writes;
// committed batches drain only after a frame boundary and only in read-free cycles.
module param_update_scheduler #(
    parameter int PARAM_WIDTH      = 36,
    parameter int PARAM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH       = 16
) (
    input logic                  clk,
    input logic                  reset,
    param_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PARAM_ADDR_WIDTH + PARAM_WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, r_remaining, w_remaining_nxt, w_post_push_count;
    logic              r_batch_done, w_batch_done_nxt;
    logic              r_tear_err;
    logic              w_ready, w_push, w_pop;
    logic [ENT_W-1:0]  w_head;

    assign w_ready           = (r_count != CNT_FULL);
    assign w_push            = bus.host_wr_valid && w_ready;
    assign w_head            = r_fifo[r_rd_ptr];
    assign w_post_push_count = w_push ? (r_count + CNT_ONE) : r_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_remaining_nxt  = r_remaining;
        w_pop            = 1'b0;
        w_batch_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                // A push in the commit cycle belongs to the batch being closed.
                if (bus.host_commit) begin
                    if (w_post_push_count != '0) begin
                        w_state_nxt     = ARMED;
                        w_remaining_nxt = w_post_push_count;
                    end else begin
                        w_batch_done_nxt = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (bus.frame_start) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!bus.dsp_rd_en && r_remaining != '0) begin
                    w_pop           = 1'b1;
                    w_remaining_nxt = r_remaining - CNT_ONE;
                    if (r_remaining == CNT_ONE) begin
                        w_state_nxt      = IDLE;
                        w_batch_done_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_batch_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_batch_done <= w_batch_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {bus.host_wr_addr, bus.host_wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tear_err <= 1'b0;
        end else if (bus.frame_start && r_state == DRAIN && r_remaining != '0) begin
            r_tear_err <= 1'b1;
        end else if (bus.clear_err) begin
            r_tear_err <= 1'b0;
        end
    end

    // Reads always win the port; the FIFO head is presented whenever the core is idle.
    assign bus.mem_rden      = bus.dsp_rd_en;
    assign bus.mem_wren      = w_pop;
    assign bus.mem_addr      = bus.dsp_rd_en ? bus.dsp_rd_addr : w_head[ENT_W-1:PARAM_WIDTH];
    assign bus.mem_data      = w_head[PARAM_WIDTH-1:0];
    assign bus.host_wr_ready = w_ready;
    assign bus.busy          = (r_state != IDLE);
    assign bus.batch_done    = r_batch_done;
    assign bus.tear_err      = r_tear_err;
endmodule

// File: tb/tb_param_update_scheduler.sv
// Scoreboard bench: a transaction-level model predicts RAM writes, batch_done
// pulses and status flags; a negedge monitor compares them against the DUT.
module tb_param_update_scheduler;
    localparam int DW    = 36;
    localparam int AW    = 10;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_update_scheduler_if #(.PARAM_WIDTH(DW), .PARAM_ADDR_WIDTH(AW)) bus ();

    param_update_scheduler #(
        .PARAM_WIDTH(DW),
        .PARAM_ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    ent_t mq[$];
    wr_t  wq[$];
    int   dq[$];
    int   m_left;
    bit   m_armed, m_drain, m_tear;

    bit            exp_busy, exp_ready, exp_tear, exp_rden, exp_has_head, last_push;
    logic [AW-1:0] exp_head_a, exp_rd_a;
    logic [DW-1:0] exp_head_d;
    int            cyc_n  = 0;
    bit            mon_en = 1'b0;
    int            errors = 0;
    int            checks = 0;
    wr_t           mon_w;

    function automatic logic [AW-1:0] rnd_a();
        logic [31:0] r;
        r = $urandom();
        return r[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_d();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d", name, cyc_n);
    endtask

    // Predicts this cycle's visible behaviour from the pending queue, then applies the cycle.
    function automatic void model_eval();
        bit was_armed, was_drain, wr;
        ent_t e;
        exp_rden = bus.dsp_rd_en;
        exp_rd_a = bus.dsp_rd_addr;
        if (reset) begin
            mq.delete(); wq.delete(); dq.delete();
            m_left = 0; m_armed = 0; m_drain = 0; m_tear = 0;
            exp_busy = 0; exp_ready = 1; exp_tear = 0; exp_has_head = 0;
            last_push = 0;
            return;
        end
        was_armed    = m_armed;
        was_drain    = m_drain;
        exp_busy     = m_armed || m_drain;
        exp_ready    = (mq.size() != DEPTH);
        exp_tear     = m_tear;
        exp_has_head = (mq.size() > 0);
        if (exp_has_head) begin
            exp_head_a = mq[0].a;
            exp_head_d = mq[0].d;
        end
        last_push = bus.host_wr_valid && exp_ready;
        wr = was_drain && !bus.dsp_rd_en;
        if (wr) begin
            e = mq.pop_front();
            wq.push_back('{cyc_n, e.a, e.d});
            m_left--;
            if (m_left == 0) begin
                m_drain = 0;
                dq.push_back(cyc_n + 1);
            end
        end
        if (was_drain && bus.frame_start) m_tear = 1;
        else if (bus.clear_err)           m_tear = 0;
        if (was_armed && bus.frame_start) begin
            m_armed = 0;
            m_drain = 1;
        end
        if (last_push) mq.push_back('{bus.host_wr_addr, bus.host_wr_data});
        if (!was_armed && !was_drain && bus.host_commit) begin
            if (mq.size() > 0) begin
                m_armed = 1;
                m_left  = mq.size();
            end else begin
                dq.push_back(cyc_n + 1);
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        cyc_n++;
        bus.frame_start = 1'b0;
        bus.host_commit = 1'b0;
        bus.clear_err   = 1'b0;
        bus.dsp_rd_addr = rnd_a();
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = a;
        bus.host_wr_data  = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_wr(a, d);
        for (int t = 0; t < 64; t++) begin
            tick();
            if (last_push) break;
        end
        if (!last_push) flag_fail("push_timeout");
        bus.host_wr_valid = 1'b0;
    endtask

    task automatic commit_tick();
        bus.host_commit = 1'b1;
        tick();
    endtask

    task automatic frame_tick();
        bus.frame_start = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && (m_armed || m_drain); t++) tick();
        if (m_armed || m_drain) flag_fail("drain_timeout");
        tick();
        tick();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mem_rden", 64'(bus.mem_rden), 64'(exp_rden));
                if (exp_rden) begin
                    chk("rd_addr", 64'(bus.mem_addr), 64'(exp_rd_a));
                end else if (!bus.mem_wren && exp_has_head) begin
                    chk("head_addr", 64'(bus.mem_addr), 64'(exp_head_a));
                    chk("head_data", 64'(bus.mem_data), 64'(exp_head_d));
                end
                if (bus.mem_wren === 1'b1) begin
                    if (wq.size() == 0) begin
                        flag_fail("unexpected_write");
                    end else begin
                        mon_w = wq.pop_front();
                        chk("wr_cycle", 64'(cyc_n), 64'(mon_w.cyc));
                        chk("wr_addr", 64'(bus.mem_addr), 64'(mon_w.a));
                        chk("wr_data", 64'(bus.mem_data), 64'(mon_w.d));
                    end
                end else if (wq.size() > 0 && wq[0].cyc <= cyc_n) begin
                    flag_fail("missing_write");
                    void'(wq.pop_front());
                end
                if (bus.batch_done === 1'b1) begin
                    if (dq.size() == 0) flag_fail("unexpected_batch_done");
                    else chk("batch_done_cycle", 64'(cyc_n), 64'(dq.pop_front()));
                end else if (dq.size() > 0 && dq[0] <= cyc_n) begin
                    flag_fail("missing_batch_done");
                    void'(dq.pop_front());
                end
                chk("busy", 64'(bus.busy), 64'(exp_busy));
                chk("host_wr_ready", 64'(bus.host_wr_ready), 64'(exp_ready));
                chk("tear_err", 64'(bus.tear_err), 64'(exp_tear));
            end
        end
    end

    initial begin
        bus.frame_start   = 1'b0;
        bus.dsp_rd_en     = 1'b0;
        bus.dsp_rd_addr   = '0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_addr  = '0;
        bus.host_wr_data  = '0;
        bus.host_commit   = 1'b0;
        bus.clear_err     = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic batch: frame boundary three cycles after the commit
        push(10'd5, 36'h123);
        push(10'd6, 36'h456);
        commit_tick();
        tick();
        tick();
        frame_tick();
        wait_idle();

        // Read priority: reads on alternating drain cycles
        for (int i = 0; i < 3; i++) push(rnd_a(), rnd_d());
        commit_tick();
        frame_tick();
        for (int i = 0; i < 8; i++) begin
            bus.dsp_rd_en = (i % 2 == 0);
            tick();
        end
        bus.dsp_rd_en = 1'b0;
        wait_idle();

        // Full FIFO: 17th push is held until the first drain write frees space
        for (int i = 0; i < DEPTH; i++) push(10'(i + 32), rnd_d());
        set_wr(10'd99, rnd_d());
        tick();
        tick();
        commit_tick();
        tick();
        frame_tick();
        for (int t = 0; t < 60 && (m_armed || m_drain || bus.host_wr_valid); t++) begin
            tick();
            if (last_push) bus.host_wr_valid = 1'b0;
        end
        bus.host_wr_valid = 1'b0;
        wait_idle();
        commit_tick();
        frame_tick();
        wait_idle();

        // Batch isolation: pushes and a commit while armed stay out of the drain
        push(rnd_a(), rnd_d());
        push(rnd_a(), rnd_d());
        commit_tick();
        for (int i = 0; i < 3; i++) push(rnd_a(), rnd_d());
        commit_tick();
        frame_tick();
        wait_idle();
        commit_tick();
        tick();
        frame_tick();
        wait_idle();

        // Tear: second frame boundary while reads stall the drain
        for (int i = 0; i < 8; i++) push(rnd_a(), rnd_d());
        commit_tick();
        bus.dsp_rd_en = 1'b1;
        frame_tick();
        tick();
        tick();
        frame_tick();
        for (int i = 0; i < 3; i++) tick();
        bus.clear_err = 1'b1;
        tick();
        tick();
        bus.clear_err = 1'b1;
        frame_tick();
        tick();
        bus.clear_err = 1'b1;
        tick();
        bus.dsp_rd_en = 1'b0;
        wait_idle();

        // Empty commit, then reset after two of four drain writes
        commit_tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) push(rnd_a(), rnd_d());
        commit_tick();
        frame_tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        commit_tick();
        tick();
        tick();

        // Randomised traffic across all inputs
        for (int i = 0; i < 600; i++) begin
            bus.dsp_rd_en     = ($urandom_range(0, 2) == 0);
            bus.host_wr_valid = $urandom_range(0, 1) == 1;
            bus.host_wr_addr  = rnd_a();
            bus.host_wr_data  = rnd_d();
            bus.host_commit   = ($urandom_range(0, 9) == 0);
            bus.frame_start   = ($urandom_range(0, 11) == 0);
            bus.clear_err     = ($urandom_range(0, 19) == 0);
            reset             = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset             = 1'b0;
        bus.host_wr_valid = 1'b0;
        bus.dsp_rd_en     = 1'b0;
        tick();
        if (m_armed) frame_tick();
        wait_idle();
        if (mq.size() > 0) begin
            commit_tick();
            frame_tick();
            wait_idle();
        end

        chk("writes_outstanding", 64'(wq.size()), 64'(0));
        chk("done_outstanding", 64'(dq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
